// File: rtl/mips_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, the architectural
// zero register, and the control bundle driven by the hazard control unit.
package mips_pkg;

    typedef enum logic [1:0] {
        HC_RUN      = 2'd0,
        HC_LU_STALL = 2'd1,
        HC_MEM_WAIT = 2'd2
    } hc_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Backward-direction control bundle, one field per output port.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic idex_hold;
        logic exmem_hold;
    } hc_ctrl_t;

    // Normal flow: everything advances, no flush (branch flush is OR-ed in separately).
    localparam hc_ctrl_t CTRL_RUN = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                      idex_bubble: 1'b0, idex_hold: 1'b0, exmem_hold: 1'b0};
    // Load-use bubble: PC and IF/ID hold, ID/EX receives zeroed control.
    localparam hc_ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                         idex_bubble: 1'b1, idex_hold: 1'b0, exmem_hold: 1'b0};
    // Data-memory wait: every register up to EX/MEM keeps its contents.
    localparam hc_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                         idex_bubble: 1'b0, idex_hold: 1'b1, exmem_hold: 1'b1};
    // While reset is asserted nothing advances and ID/EX is filled with a NOP.
    localparam hc_ctrl_t CTRL_RESET = CTRL_BUBBLE;

endpackage

// File: rtl/sat_counter.sv
// Enable-driven up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: increment only when enabled and not yet saturated.
    always_comb begin
        count_d = count_q;
        if (enable && (count_q != {W{1'b1}})) begin
            count_d = count_q + ONE;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Hold / bubble / flush control for PC, IF/ID, ID/EX and EX/MEM. Handles
// multi-cycle load-use stalls, data-memory wait states and taken-branch flushes,
// and keeps saturating stall and flush counters.
module hazard_control_unit
    import mips_pkg::*;
#(
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch_taken,
    input  logic             ex_mem_ren,
    input  logic [4:0]       ex_rt,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // Counter reload on a fresh hazard: the first bubble is issued from RUN.
    localparam logic [2:0] LU_RELOAD = 3'(LOAD_STALL - 1);

    hc_state_e  state_q, state_d;
    hc_state_e  ret_q, ret_d;
    hc_state_e  eff_state;
    logic [2:0] lu_cnt_q, lu_cnt_d;
    logic       lu_hit;
    logic       mem_stall;
    hc_ctrl_t   ctrl;

    assign lu_hit = ex_mem_ren && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign mem_stall = mem_req && !mem_ready;

    // On the cycle a wait ends, behave as the state the wait interrupted.
    assign eff_state = (state_q == HC_MEM_WAIT) ? ret_q : state_q;

    // Next-state and Mealy output decode, priority mem_stall > load-use > branch.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        ctrl     = CTRL_RUN;
        state_d  = state_q;
        ret_d    = ret_q;
        lu_cnt_d = lu_cnt_q;

        if (mem_stall) begin
            ctrl    = CTRL_FREEZE;
            state_d = HC_MEM_WAIT;
            if (state_q != HC_MEM_WAIT) begin
                ret_d = state_q;
            end
        end else begin
            state_d = HC_RUN;
            case (eff_state)
                HC_LU_STALL: begin
                    ctrl     = CTRL_BUBBLE;
                    lu_cnt_d = lu_cnt_q - 3'd1;
                    if (lu_cnt_q != 3'd1) begin
                        state_d = HC_LU_STALL;
                    end
                end
                default: begin
                    if (lu_hit) begin
                        ctrl = CTRL_BUBBLE;
                        if (LOAD_STALL > 1) begin
                            lu_cnt_d = LU_RELOAD;
                            state_d  = HC_LU_STALL;
                        end
                    end else begin
                        // A branch is only flushed when nothing is holding ID.
                        ctrl.ifid_flush = id_branch_taken;
                    end
                end
            endcase
        end

        if (reset) begin
            ctrl = CTRL_RESET;
        end
    end

    // State, return-state and bubble-counter registers.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q  <= HC_RUN;
            ret_q    <= HC_RUN;
            lu_cnt_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_bubble = ctrl.idex_bubble;
    assign idex_hold   = ctrl.idex_hold;
    assign exmem_hold  = ctrl.exmem_hold;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock  (clock),
        .reset  (reset),
        .enable (!ctrl.pc_write),
        .count  (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock  (clock),
        .reset  (reset),
        .enable (ctrl.ifid_flush),
        .count  (flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two instances (LOAD_STALL=1/CNT_W=16 and
// LOAD_STALL=3/CNT_W=4) share one stimulus stream and are compared every cycle
// against a "bubbles still owed" reference model, plus directed scenarios.
module tb_hazard_control_unit;

    localparam int LS_A = 1;
    localparam int LS_B = 3;
    localparam int MAX_A = 65535;
    localparam int MAX_B = 15;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       br;
        logic       ren;
        logic [4:0] ert;
        logic       req;
        logic       rdy;
    } stim_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, id_branch_taken, ex_mem_ren, mem_req, mem_ready;

    logic        pc_write_a, ifid_write_a, ifid_flush_a, idex_bubble_a, idex_hold_a, exmem_hold_a;
    logic [15:0] stall_cycles_a, flush_count_a;
    logic        pc_write_b, ifid_write_b, ifid_flush_b, idex_bubble_b, idex_hold_b, exmem_hold_b;
    logic [3:0]  stall_cycles_b, flush_count_b;

    int checks = 0;
    int errors = 0;
    int owed_a, sc_a, fc_a;
    int owed_b, sc_b, fc_b;

    hazard_control_unit #(.LOAD_STALL(LS_A), .CNT_W(16)) dut_a (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_branch_taken(id_branch_taken), .ex_mem_ren(ex_mem_ren), .ex_rt(ex_rt),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write_a), .ifid_write(ifid_write_a),
        .ifid_flush(ifid_flush_a), .idex_bubble(idex_bubble_a), .idex_hold(idex_hold_a),
        .exmem_hold(exmem_hold_a), .stall_cycles(stall_cycles_a), .flush_count(flush_count_a)
    );

    hazard_control_unit #(.LOAD_STALL(LS_B), .CNT_W(4)) dut_b (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_branch_taken(id_branch_taken), .ex_mem_ren(ex_mem_ren), .ex_rt(ex_rt),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write_b), .ifid_write(ifid_write_b),
        .ifid_flush(ifid_flush_b), .idex_bubble(idex_bubble_b), .idex_hold(idex_hold_b),
        .exmem_hold(exmem_hold_b), .stall_cycles(stall_cycles_b), .flush_count(flush_count_b)
    );

    // ---------------- reference model ----------------
    function automatic stim_t mk(int rs, int rt, bit uses, bit br, bit ren, int ert, bit req, bit rdy);
        stim_t s;
        s.rs = 5'(rs); s.rt = 5'(rt); s.uses_rt = uses; s.br = br;
        s.ren = ren; s.ert = 5'(ert); s.req = req; s.rdy = rdy;
        return s;
    endfunction

    function automatic bit ref_lu_hit();
        return ex_mem_ren && (ex_rt != 0) && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

    // Expected {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold}.
    function automatic logic [5:0] model_ctrl(int owed);
        if (reset) return 6'b000100;
        if (mem_req && !mem_ready) return 6'b000011;
        if (owed > 0 || ref_lu_hit()) return 6'b000100;
        return {2'b11, id_branch_taken, 3'b000};
    endfunction

    task automatic advance_model(inout int owed, inout int sc, inout int fc, input int ls, input int maxc);
        logic [5:0] c;
        c = model_ctrl(owed);
        if (reset) begin
            owed = 0; sc = 0; fc = 0;
            return;
        end
        if (!c[5] && sc < maxc) sc++;
        if (c[3] && fc < maxc) fc++;
        if (mem_req && !mem_ready) begin
            // frozen: bubbles still owed are kept for later
        end else if (owed > 0) begin
            owed--;
        end else if (ref_lu_hit()) begin
            owed = ls - 1;
        end
    endtask

    function automatic logic [37:0] obs_a();
        return {pc_write_a, ifid_write_a, ifid_flush_a, idex_bubble_a, idex_hold_a, exmem_hold_a,
                stall_cycles_a, flush_count_a};
    endfunction
    function automatic logic [37:0] exp_a();
        return {model_ctrl(owed_a), 16'(sc_a), 16'(fc_a)};
    endfunction
    function automatic logic [13:0] obs_b();
        return {pc_write_b, ifid_write_b, ifid_flush_b, idex_bubble_b, idex_hold_b, exmem_hold_b,
                stall_cycles_b, flush_count_b};
    endfunction
    function automatic logic [13:0] exp_b();
        return {model_ctrl(owed_b), 4'(sc_b), 4'(fc_b)};
    endfunction

    task automatic drive(input stim_t s);
        id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.uses_rt; id_branch_taken = s.br;
        ex_mem_ren = s.ren; ex_rt = s.ert; mem_req = s.req; mem_ready = s.rdy;
    endtask

    task automatic set_reset(input bit v);
        reset = v;
        if (v) begin
            owed_a = 0; sc_a = 0; fc_a = 0;
            owed_b = 0; sc_b = 0; fc_b = 0;
        end
    endtask

    // Model follows the coming rising edge, then move to the next drive point.
    task automatic tick();
        advance_model(owed_a, sc_a, fc_a, LS_A, MAX_A);
        advance_model(owed_b, sc_b, fc_b, LS_B, MAX_B);
        @(negedge clock);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        set_reset(1'b1);
        @(negedge clock);
        #1;
        checks++;
        if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
            errors++; $display("FAIL reset_vs_model: dut=%h model=%h", {obs_a(), obs_b()}, {exp_a(), exp_b()});
        end
        checks++;
        if ({pc_write_a, ifid_write_a, idex_bubble_a, stall_cycles_a} !== {1'b0, 1'b0, 1'b1, 16'd0}) begin
            errors++; $display("FAIL reset_outputs: dut pc/ifid/bubble/stall=%b%b%b/%0d required 001/0",
                               pc_write_a, ifid_write_a, idex_bubble_a, stall_cycles_a);
        end
        tick();
        set_reset(1'b0);
        #1;
        checks++;
        if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
            errors++; $display("FAIL reset_release: dut=%h model=%h", {obs_a(), obs_b()}, {exp_a(), exp_b()});
        end
        tick();
    endtask

    task automatic test_load_use();
        stim_t s[2];
        s[0] = mk(5, 0, 0, 0, 1, 5, 0, 0);
        s[1] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            drive(s[i]);
            #1;
            checks++;
            if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
                errors++; $display("FAIL load_use cyc%0d: dut=%h model=%h", i, {obs_a(), obs_b()}, {exp_a(), exp_b()});
            end
            if (i == 0) begin
                checks++;
                if ({pc_write_a, ifid_write_a, idex_bubble_a} !== 3'b001) begin
                    errors++; $display("FAIL load_use_bubble: dut=%b required 001", {pc_write_a, ifid_write_a, idex_bubble_a});
                end
            end else begin
                checks++;
                if ({pc_write_a, stall_cycles_a} !== {1'b1, 16'd1}) begin
                    errors++; $display("FAIL load_use_after: dut pc=%b stall=%0d required pc=1 stall=1", pc_write_a, stall_cycles_a);
                end
            end
            tick();
        end
    endtask

    task automatic test_no_stall_cases();
        stim_t s[2];
        s[0] = mk(0, 0, 0, 0, 1, 0, 0, 0);  // load to r0
        s[1] = mk(3, 7, 0, 0, 1, 7, 0, 0);  // rt matches but not a source
        for (int i = 0; i < 2; i++) begin
            drive(s[i]);
            #1;
            checks++;
            if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
                errors++; $display("FAIL no_stall cyc%0d: dut=%h model=%h", i, {obs_a(), obs_b()}, {exp_a(), exp_b()});
            end
            checks++;
            if ({pc_write_a, idex_bubble_a} !== 2'b10) begin
                errors++; $display("FAIL no_stall_pc cyc%0d: dut pc/bubble=%b required 10", i, {pc_write_a, idex_bubble_a});
            end
            tick();
        end
    endtask

    task automatic test_mem_wait();
        int base;
        base = int'(stall_cycles_a);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(mk(0, 0, 0, 0, 0, 0, 1, 0));
            else if (i == 3) drive(mk(0, 0, 0, 0, 0, 0, 1, 1));
            else drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
            #1;
            checks++;
            if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
                errors++; $display("FAIL mem_wait cyc%0d: dut=%h model=%h", i, {obs_a(), obs_b()}, {exp_a(), exp_b()});
            end
            checks++;
            if ({pc_write_a, idex_hold_a, exmem_hold_a} !== ((i < 3) ? 3'b011 : 3'b100)) begin
                errors++; $display("FAIL mem_wait_ctrl cyc%0d: dut pc/idex_hold/exmem_hold=%b", i,
                                   {pc_write_a, idex_hold_a, exmem_hold_a});
            end
            if (i == 4) begin
                checks++;
                if (int'(stall_cycles_a) !== base + 3) begin
                    errors++; $display("FAIL mem_wait_count: dut=%0d required %0d", stall_cycles_a, base + 3);
                end
            end
            tick();
        end
    endtask

    task automatic test_branch_with_load_use();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(mk(9, 0, 0, 1, 1, 9, 0, 0));
            else if (i == 1) drive(mk(9, 0, 0, 1, 0, 0, 0, 0));
            else drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
            #1;
            checks++;
            if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
                errors++; $display("FAIL branch_lu cyc%0d: dut=%h model=%h", i, {obs_a(), obs_b()}, {exp_a(), exp_b()});
            end
            checks++;
            if ({ifid_flush_a, idex_bubble_a, flush_count_a} !==
                ((i == 0) ? {2'b01, 16'd0} : (i == 1) ? {2'b10, 16'd0} : {2'b00, 16'd1})) begin
                errors++; $display("FAIL branch_lu_ctrl cyc%0d: dut flush/bubble=%b%b flush_count=%0d", i,
                                   ifid_flush_a, idex_bubble_a, flush_count_a);
            end
            tick();
        end
    endtask

    // LOAD_STALL=3 instance: bubble, 2 frozen cycles, 2 more bubbles, then RUN.
    task automatic test_lu_stall_mem_freeze();
        logic [2:0] want [6] = '{3'b010, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100};
        for (int i = 0; i < 3; i++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 0) drive(mk(4, 0, 0, 0, 1, 4, 0, 0));
            else if (i < 3) drive(mk(0, 0, 0, 0, 0, 0, 1, 0));
            else if (i == 3) drive(mk(0, 0, 0, 0, 0, 0, 1, 1));
            else drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
            #1;
            checks++;
            if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
                errors++; $display("FAIL lu_freeze cyc%0d: dut=%h model=%h", i, {obs_a(), obs_b()}, {exp_a(), exp_b()});
            end
            checks++;
            if ({pc_write_b, idex_bubble_b, exmem_hold_b} !== want[i]) begin
                errors++; $display("FAIL lu_freeze_seq cyc%0d: dut pc/bubble/exmem_hold=%b required %b", i,
                                   {pc_write_b, idex_bubble_b, exmem_hold_b}, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_wait();
        drive(mk(0, 0, 0, 0, 0, 0, 1, 0));
        tick();
        tick();
        set_reset(1'b1);
        #1;
        checks++;
        if ({stall_cycles_a, flush_count_a, stall_cycles_b, idex_bubble_a, exmem_hold_a} !== {16'd0, 16'd0, 4'd0, 2'b10}) begin
            errors++; $display("FAIL reset_mid_wait: dut stall=%0d flush=%0d stall_b=%0d bubble=%b exmem_hold=%b",
                               stall_cycles_a, flush_count_a, stall_cycles_b, idex_bubble_a, exmem_hold_a);
        end
        tick();
        set_reset(1'b0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        checks++;
        if ({pc_write_a, pc_write_b, exmem_hold_a, exmem_hold_b} !== 4'b1100) begin
            errors++; $display("FAIL reset_mid_wait_run: dut pc_a/pc_b/hold_a/hold_b=%b required 1100",
                               {pc_write_a, pc_write_b, exmem_hold_a, exmem_hold_b});
        end
        tick();
    endtask

    task automatic test_saturation();
        drive(mk(0, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 20; i++) tick();
        #1;
        checks++;
        if ({stall_cycles_b, stall_cycles_a} !== {4'd15, 16'd20}) begin
            errors++; $display("FAIL saturation: dut stall_b=%0d stall_a=%0d required 15/20", stall_cycles_b, stall_cycles_a);
        end
        for (int i = 0; i < 3; i++) tick();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        checks++;
        if ({obs_a(), obs_b()} !== {exp_a(), exp_b()} || stall_cycles_b !== 4'd15) begin
            errors++; $display("FAIL saturation_hold: dut stall_b=%0d required 15 (model %h dut %h)",
                               stall_cycles_b, {exp_a(), exp_b()}, {obs_a(), obs_b()});
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 79) == 0) set_reset(1'b1);
            else if (reset) set_reset(1'b0);
            drive(mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                     ($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1))));
            #1;
            checks++;
            if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
                errors++; $display("FAIL random cyc%0d: dut=%h model=%h", i, {obs_a(), obs_b()}, {exp_a(), exp_b()});
            end
            tick();
        end
        set_reset(1'b0);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall_cases();
        test_mem_wait();
        test_branch_with_load_use();
        test_lu_stall_mem_freeze();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
